// File: rtl/noc_traffic_gen.sv
// rtl/noc_traffic_gen.sv - per-node NoC packet source with selectable traffic pattern
// Emits multi-flit packets (head/body/tail) under valid/ready, rotating VCs per packet.
module noc_traffic_gen #(
  parameter int NUM_OF_NODES            = 8,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int NODE_ID                 = 0,
  parameter int PACKET_LENGTH           = 4,
  parameter int NUM_OF_PACKETS          = 4,
  parameter int INTER_PACKET_GAP        = 2,
  localparam int DEST_NODE_WIDTH        = $clog2(NUM_OF_NODES),
  localparam int VC_WIDTH               = $clog2(NUM_OF_VIRTUAL_CHANNELS),
  localparam int FLIT_TOTAL_WIDTH       = 2 + VC_WIDTH + FLIT_DATA_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic                        i_flit_ready,
  output logic [FLIT_TOTAL_WIDTH-1:0] o_flit_out,
  output logic                        o_flit_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [7:0]                  o_packets_sent
);

  localparam int DW   = DEST_NODE_WIDTH;
  localparam int FDW  = FLIT_DATA_WIDTH;
  localparam int IDXW = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1;
  localparam logic [DW-1:0]   SELF      = DW'(NODE_ID);
  localparam logic [IDXW-1:0] LAST_BODY = IDXW'((PACKET_LENGTH >= 2) ? PACKET_LENGTH - 2 : 0);
  localparam logic [7:0]      LAST_PKT  = 8'(NUM_OF_PACKETS - 1);
  localparam logic [3:0]      GAP_LAST  = 4'((INTER_PACKET_GAP > 0) ? INTER_PACKET_GAP - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL, S_GAP, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DW-1:0]         r_dest, w_dest_nxt, w_dest;
  logic [7:0]            r_seq, w_seq_nxt;
  logic [IDXW-1:0]       r_idx, w_idx_nxt;
  logic [3:0]            r_gap, w_gap_nxt;
  logic [7:0]            r_sent, w_sent_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [FLIT_TOTAL_WIDTH-1:0] r_flit, w_flit_nxt;
  logic                  w_accept, w_tail_acc;
  logic [1:0]            w_type;
  logic [VC_WIDTH-1:0]   w_vc;
  logic [FDW-1:0]        w_payload;

  assign w_accept   = r_valid && i_flit_ready;
  assign w_tail_acc = w_accept && (r_state == S_TAIL || (r_state == S_HEAD && PACKET_LENGTH == 1));

  // Ring arithmetic wraps by truncation since the node count is a power of two.
  always_comb begin
    case (i_mode)
      2'd0:    w_dest = DW'(NODE_ID + 1);
      2'd1:    w_dest = '0;
      2'd2:    w_dest = DW'(NODE_ID + NUM_OF_NODES - 1);
      default: w_dest = DW'(NODE_ID + NUM_OF_NODES / 2);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_dest  <= '0;
      r_seq   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_sent  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_flit  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dest  <= w_dest_nxt;
      r_seq   <= w_seq_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_sent  <= w_sent_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_flit  <= w_flit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dest_nxt  = r_dest;
    w_seq_nxt   = r_seq;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_sent_nxt  = r_sent;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_dest_nxt = w_dest;
          w_sent_nxt = '0;
          w_seq_nxt  = '0;
          w_idx_nxt  = '0;
          if (w_dest == SELF) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_HEAD;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
          end
        end
      end
      S_HEAD: begin
        if (w_accept && PACKET_LENGTH > 1) begin
          w_state_nxt = (PACKET_LENGTH == 2) ? S_TAIL : S_BODY;
          w_idx_nxt   = IDXW'(1);
        end
      end
      S_BODY: begin
        if (w_accept) begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST_BODY) w_state_nxt = S_TAIL;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = S_HEAD;
        else                   w_gap_nxt   = r_gap + 1'b1;
      end
      default: ;
    endcase
    if (w_tail_acc) begin
      w_sent_nxt = r_sent + 8'd1;
      w_seq_nxt  = r_seq + 8'd1;
      w_idx_nxt  = '0;
      w_gap_nxt  = '0;
      if (r_sent == LAST_PKT) begin
        w_state_nxt = S_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end else if (INTER_PACKET_GAP > 0) begin
        w_state_nxt = S_GAP;
      end else begin
        w_state_nxt = S_HEAD;
      end
    end
  end

  // Flit is built from next-state values so it lands in a register with no ready-to-output path.
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_HEAD) || (w_state_nxt == S_BODY) || (w_state_nxt == S_TAIL);
    w_vc        = VC_WIDTH'(w_seq_nxt % NUM_OF_VIRTUAL_CHANNELS);
    w_payload   = '0;
    w_type      = 2'b00;
    if (w_state_nxt == S_HEAD) begin
      w_type                      = (PACKET_LENGTH == 1) ? 2'b11 : 2'b01;
      w_payload[FDW-1 -: DW]      = w_dest_nxt;
      w_payload[FDW-DW-1 -: DW]   = SELF;
    end else begin
      w_type                      = (w_state_nxt == S_BODY) ? 2'b10 : 2'b00;
      w_payload[FDW-1 -: DW]      = SELF;
      w_payload[FDW-DW-1 -: 8]    = w_seq_nxt;
      w_payload[IDXW-1:0]         = w_idx_nxt;
    end
    w_flit_nxt = w_valid_nxt ? {w_type, w_vc, w_payload} : '0;
  end

  assign o_flit_out     = r_flit;
  assign o_flit_valid   = r_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_packets_sent = r_sent;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb/tb_noc_traffic_gen.sv - self-checking bench for noc_traffic_gen
module tb_noc_traffic_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [3];
  logic [1:0] mode  [3];
  logic       ready [3];
  logic [18:0] flit [3];
  logic       valid [3];
  logic       busy  [3];
  logic       done  [3];
  logic [7:0] sent  [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_traffic_gen #(.NODE_ID(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_mode(mode[0]), .i_flit_ready(ready[0]),
    .o_flit_out(flit[0]), .o_flit_valid(valid[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_packets_sent(sent[0]));

  noc_traffic_gen #(.NODE_ID(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_mode(mode[1]), .i_flit_ready(ready[1]),
    .o_flit_out(flit[1]), .o_flit_valid(valid[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_packets_sent(sent[1]));

  noc_traffic_gen #(.NODE_ID(3), .PACKET_LENGTH(1), .INTER_PACKET_GAP(0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_mode(mode[2]), .i_flit_ready(ready[2]),
    .o_flit_out(flit[2]), .o_flit_valid(valid[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_packets_sent(sent[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_of(input int node, input int m);
    case (m)
      0:       return (node + 1) % 8;
      1:       return 0;
      2:       return (node + 7) % 8;
      default: return (node + 4) % 8;
    endcase
  endfunction

  // Reference: 8 nodes, 16-bit payload, 2 VCs, 4 packets; fields placed with plain shifts.
  task automatic run(input int d, input int node, input int m, input int pl, input int gap,
                     input bit rnd, input int inject_cyc);
    logic [31:0] exp_flit[$];
    int          exp_cyc[$];
    int          dst, k, cyc, typ;
    logic [31:0] held, pay;
    bit          holding;
    dst = dest_of(node, m);
    if (dst != node) begin
      for (int p = 0; p < 4; p++) begin
        for (int i = 0; i < pl; i++) begin
          typ = (pl == 1) ? 3 : (i == 0) ? 1 : (i == pl - 1) ? 0 : 2;
          pay = (i == 0) ? ((dst << 13) | (node << 10)) : ((node << 13) | (p << 5) | i);
          exp_flit.push_back((typ << 17) | ((p % 2) << 16) | pay);
          exp_cyc.push_back(1 + p * (pl + gap) + i);
        end
      end
    end
    @(negedge clk);
    start[d] = 1'b1;
    mode[d]  = 2'(m);
    ready[d] = 1'b0;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    check("busy_after_start", busy[d], dst != node);
    check("done_after_start", done[d], dst == node);
    check("sent_cleared", sent[d], 0);
    holding = 1'b0;
    k = 0;
    while (k < exp_flit.size() && cyc < 3000) begin
      if (holding) begin
        check("hold_valid", valid[d], 1);
        check("hold_flit", flit[d], held);
      end
      if (cyc == inject_cyc) begin
        start[d] = 1'b1;
        mode[d]  = 2'((m + 1) % 4);
      end else begin
        start[d] = 1'b0;
      end
      ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid[d] && ready[d]) begin
        check("flit", flit[d], exp_flit[k]);
        if (!rnd) check("flit_cycle", cyc, exp_cyc[k]);
        k++;
        holding = 1'b0;
      end else if (valid[d]) begin
        holding = 1'b1;
        held    = 32'(flit[d]);
      end
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    ready[d] = 1'b1;
    check("all_flits_accepted", k, exp_flit.size());
    check("done_at_end", done[d], 1);
    check("busy_at_end", busy[d], 0);
    check("packets_sent", sent[d], (dst == node) ? 0 : 4);
    for (int j = 0; j < 3; j++) begin
      check("no_extra_flit", valid[d], 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      mode[d]  = 2'd0;
      ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_flit", flit[0], 0);
    check("rst_valid", valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_sent", sent[0], 0);
    rst_n = 1'b1;

    run(0, 1, 0, 4, 2, 1'b0, -1);
    run(0, 1, 0, 4, 2, 1'b1, -1);
    run(1, 0, 1, 4, 2, 1'b0, -1);
    run(2, 3, 3, 1, 0, 1'b0, -1);
    run(0, 1, 0, 4, 2, 1'b0, 3);

    @(negedge clk);
    start[0] = 1'b1;
    mode[0]  = 2'd0;
    ready[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    ready[0] = 1'b1;
    @(negedge clk);
    ready[0] = 1'b0;
    check("stall_body", flit[0], 32'h42001);
    @(negedge clk);
    check("stall_body_held", flit[0], 32'h42001);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_flit", flit[0], 0);
    check("midrst_valid", valid[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_done", done[0], 0);
    check("midrst_sent", sent[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1, 0, 4, 2, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
